sda_rx_decode: RTL

SDA_RX_DECODE -- requirements
Module: sda_rx_decode

---
 rtl/sda_rx_decode.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sda_rx_decode.sv
// sda_rx_decode: receives a 4-bit nibble framed by START/STOP on an scl/sda
// pair, presents it on dout with a one-hot copy on outhigh, and flags
// malformed, aborted or stalled frames on frm_err.
module sda_rx_decode #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda,
    output logic [3:0]  dout,
    output logic        dvalid,
    output logic [15:0] outhigh,
    output logic        frm_err,
    output logic        busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT3,
        ST_BIT2,
        ST_BIT1,
        ST_BIT0,
        ST_WSTOP
    } state_t;

    state_t         state_q, state_d;
    logic           s_scl_q, p_scl_q, s_sda_q, p_sda_q;
    logic [3:0]     shift_q, shift_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     dout_q, dout_d;
    logic [15:0]    outhigh_q, outhigh_d;
    logic           dvalid_q, dvalid_d;
    logic           frm_err_q, frm_err_d;
    logic           busy_q, busy_d;

    logic           start_ev, stop_ev, rise_ev;
    logic [1:0]     bit_idx;
    state_t         bit_next;

    assign start_ev = p_sda_q & ~s_sda_q & s_scl_q;
    assign stop_ev  = ~p_sda_q & s_sda_q & s_scl_q;
    assign rise_ev  = ~p_scl_q & s_scl_q;

    // Which shift bit the current data state captures, and where it goes next.
    always_comb begin
        bit_idx  = 2'd3;
        bit_next = ST_WSTOP;
        case (state_q)
            ST_BIT3: begin bit_idx = 2'd3; bit_next = ST_BIT2;  end
            ST_BIT2: begin bit_idx = 2'd2; bit_next = ST_BIT1;  end
            ST_BIT1: begin bit_idx = 2'd1; bit_next = ST_BIT0;  end
            ST_BIT0: begin bit_idx = 2'd0; bit_next = ST_WSTOP; end
            default: begin bit_idx = 2'd3; bit_next = ST_WSTOP; end
        endcase
    end

    // Frame FSM next-state: START/STOP outrank RISE, RISE outranks timeout.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        outhigh_d = outhigh_q;
        dvalid_d  = 1'b0;
        frm_err_d = 1'b0;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (start_ev) begin
                state_d = ST_BIT3;
                shift_d = '0;
            end
        end else if (start_ev) begin
            frm_err_d = 1'b1;
            state_d   = ST_BIT3;
            shift_d   = '0;
            cnt_d     = '0;
        end else if (stop_ev) begin
            if (state_q == ST_WSTOP) begin
                dout_d    = shift_q;
                outhigh_d = 16'(1) << shift_q;
                dvalid_d  = 1'b1;
            end else begin
                frm_err_d = 1'b1;
            end
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (rise_ev) begin
            if (state_q == ST_WSTOP) begin
                frm_err_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                shift_d[bit_idx] = s_sda_q;
                state_d          = bit_next;
            end
            cnt_d = '0;
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
            // Count reaches TIMEOUT on this edge; leaving IDLE-bound means
            // the counter never has to wrap, which gives saturation for free.
            frm_err_d = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Input synchronisers plus all FSM state and registered outputs.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            s_scl_q   <= 1'b1;
            p_scl_q   <= 1'b1;
            s_sda_q   <= 1'b1;
            p_sda_q   <= 1'b1;
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            outhigh_q <= '0;
            dvalid_q  <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            s_scl_q   <= scl;
            p_scl_q   <= s_scl_q;
            s_sda_q   <= sda;
            p_sda_q   <= s_sda_q;
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            outhigh_q <= outhigh_d;
            dvalid_q  <= dvalid_d;
            frm_err_q <= frm_err_d;
            busy_q    <= busy_d;
        end
    end

    assign dout    = dout_q;
    assign outhigh = outhigh_q;
    assign dvalid  = dvalid_q;
    assign frm_err = frm_err_q;
    assign busy    = busy_q;

endmodule
